// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and a buffered mul/div unit
//   in : clk, rst, pipe_we/pipe_wn/pipe_wd, md_valid/md_wn/md_wd, RN1, RN2
//   out: md_ready, stall_req, count, pend1, pend2, RegWrite/WN/WD (registered)
module wb_port_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_we,
   input  logic [4:0]    pipe_wn,
   input  logic [31:0]   pipe_wd,
   input  logic          md_valid,
   input  logic [4:0]    md_wn,
   input  logic [31:0]   md_wd,
   output logic          md_ready,
   input  logic [4:0]    RN1,
   input  logic [4:0]    RN2,
   output logic          pend1,
   output logic          pend2,
   output logic          stall_req,
   output logic [AW:0]   count,
   output logic          RegWrite,
   output logic [4:0]    WN,
   output logic [31:0]   WD
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [4:0]    fn_q [DEPTH];
   logic [31:0]   fd_q [DEPTH];
   logic [AW-1:0] rp_q, wp_q;
   logic [AW:0]   count_q;
   logic          rw_q;
   logic [4:0]    wnr_q;
   logic [31:0]   wdr_q;
   logic          pipe, push, pop, p1, p2;
   assign md_ready  = !rst && count_q < FULL;
   assign stall_req = count_q == FULL;
   assign count     = count_q;
   assign RegWrite  = rw_q;
   assign WN        = wnr_q;
   assign WD        = wdr_q;
   assign pipe      = pipe_we && pipe_wn != 5'd0;
   assign push      = md_valid && md_ready && md_wn != 5'd0;
   assign pop       = !pipe && count_q != '0;
   always_comb begin
      p1 = rw_q && wnr_q == RN1;
      p2 = rw_q && wnr_q == RN2;
      for (int i = 0; i < DEPTH; i++) begin
         if ({1'b0, AW'(AW'(i) - rp_q)} < count_q) begin
            p1 = p1 | (fn_q[i] == RN1);
            p2 = p2 | (fn_q[i] == RN2);
         end
      end
   end
   assign pend1 = RN1 != 5'd0 && p1;
   assign pend2 = RN2 != 5'd0 && p2;
   always_ff @(posedge clk) begin
      if (rst) begin
         rp_q    <= '0;
         wp_q    <= '0;
         count_q <= '0;
         rw_q    <= 1'b0;
         wnr_q   <= '0;
         wdr_q   <= '0;
      end else begin
         if (push) begin
            fn_q[wp_q] <= md_wn;
            fd_q[wp_q] <= md_wd;
            wp_q       <= wp_q + 1'b1;
         end
         if (pop) rp_q <= rp_q + 1'b1;
         count_q <= push && !pop ? count_q + 1'b1 : pop && !push ? count_q - 1'b1 : count_q;
         rw_q    <= pipe || pop;
         if (pipe) begin
            wnr_q <= pipe_wn;
            wdr_q <= pipe_wd;
         end else if (pop) begin
            wnr_q <= fn_q[rp_q];
            wdr_q <= fd_q[rp_q];
         end
      end
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two writers:
  - the main pipeline writeback, which always has priority and is never held off;
  - a long-latency multiply/divide unit, whose results are buffered in a small FIFO and drained into idle write-port cycles.
- Sits between the writeback stage, the mul/div unit and the register file.
- Drives the register file's RegWrite/WN/WD from registered outputs.
- Gives decode per-read-port "pending" flags so it can stall on queued results.

Parameters:
- DEPTH, 4, FIFO entries for mul/div results; power of two, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- pipe_we  in  1  pipeline writeback request.
- pipe_wn  in  5  pipeline destination register.
- pipe_wd  in  32  pipeline write data.
- md_valid  in  1  mul/div result valid.
- md_wn  in  5  mul/div destination register.
- md_wd  in  32  mul/div result.
- md_ready  out  1  FIFO can accept a result.
- RN1  in  5  decode read register, port 1.
- RN2  in  5  decode read register, port 2.
- pend1  out  1  RN1 has an uncommitted mul/div or in-flight write.
- pend2  out  1  RN2 has an uncommitted mul/div or in-flight write.
- stall_req  out  1  FIFO full; upstream must not issue new mul/div ops.
- count  out  AW+1  current FIFO occupancy.
- RegWrite  out  1  register-file write enable.
- WN  out  5  register-file write address.
- WD  out  32  register-file write data.

Behaviour:
- Reset: all of the following are 0, and all queued entries are discarded:
  - count, read pointer, write pointer;
  - RegWrite, WN, WD;
  - md_ready (held 0 while rst=1).
- Reset during operation has the same effect; no partial write is issued.
- Writes to r0:
  - pipe_we with pipe_wn=0 is treated as no request.
  - A handshake with md_wn=0 completes (md_ready honoured) but nothing is enqueued.
- Enqueue:
  - md_ready = !rst && (count < DEPTH); combinational from count only.
  - A same-cycle pop does not raise md_ready.
  - A push occurs on an edge where md_valid && md_ready && md_wn!=0; the entry is written at the write pointer and the pointer wraps modulo DEPTH.
- Selection at each rising edge (outputs registered):
  - Case A, pipe_we && pipe_wn!=0: load RegWrite=1, WN=pipe_wn, WD=pipe_wd; FIFO head not popped.
  - Case B, otherwise if count>0: load the head entry, RegWrite=1; read pointer advances with wrap.
  - Case C, otherwise: RegWrite=0; WN and WD hold their previous values.
- Count update on the same edge:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Push and pop in the same cycle with count=0 is impossible; there is no empty-FIFO bypass.
- Latency:
  - Pipeline request sampled at edge k: RegWrite high after edge k; register file commits at edge k+1.
  - Mul/div result accepted at edge k: earliest RegWrite after edge k+1; commit at edge k+2.
- Ordering: FIFO entries drain strictly in acceptance order.
- Starvation: a mul/div entry may wait indefinitely while the pipeline writes every cycle.
- stall_req = (count == DEPTH), combinational.
- pend1 = (RN1 != 0) && (RN1 matches wn of any occupied FIFO entry, or RegWrite && WN==RN1).
  - pend2 is identical, using RN2.
  - Both are combinational from the current state.
- Correct WAW/RAW ordering between the pipeline and mul/div results is upstream's responsibility, enforced via pend1/pend2.
- Unknown or X inputs while rst=1 have no effect.

Test Plan:
- Pipeline only: pipe_we=1, pipe_wn=5, pipe_wd=0x1234 at edge k → after k, RegWrite=1, WN=5, WD=0x1234. Next cycle pipe_we=0 → RegWrite=0.
- Mul/div drain in idle slots: with pipe_we=0, push (7,0xA) at edge k → count=1 after k. After k+1: RegWrite=1, WN=7, WD=0xA, count=0. While queued, RN1=7 → pend1=1.
- Pipeline priority, FIFO full:
  - pipe_we=1 every cycle; push 4 entries (wn 1..4) → count=4, md_ready=0, stall_req=1.
  - Drop pipe_we → entries 1,2,3,4 appear on WN over 4 consecutive cycles in order.
  - md_ready rises the cycle after the first pop.
- Simultaneous push and pop with count=2: count stays 2 and the pointers wrap correctly across 3 full DEPTH cycles (12 pushes); data order is preserved.
- r0 handling:
  - pipe_we=1 with pipe_wn=0 while FIFO holds (3,0xB) → the FIFO entry is popped that cycle.
  - md push with wn=0 → count unchanged.
  - RN1=0 → pend1=0.
- Reset mid-operation: count=3 with RegWrite=1, assert rst for one edge → count=0, RegWrite=0, WN=0, WD=0, pend1=pend2=0. The discarded entries never reach WN.
